prog_run_sequencer: RTL
=======================

Name: prog_run_sequencer

Overview:
Run controller for the 9-bit-instruction single-cycle core. It owns the data-memory port and shares it between three masters: a preload stream, the core, and a post-halt readback port. It sequences each run through preload, hold of the core in init, free run until the core's halt flag or a timeout, then result readback. It sits between the top-level harness and the core's start input, halt output and data_mem.

Parameters:
AW, 8, data memory address width
DW, 8, data memory word width
INIT_CYCLES, 2, cycles core_start is held high after preload (>=1)
MAX_CYCLES, 16'hFFFF, RUN-cycle budget before timeout (>=1)

Ports:
CLK  in  1  clock, posedge
reset  in  1  synchronous, active-high
go  in  1  pulse; starts a run from IDLE, DONE or TIMEOUT
load_valid  in  1  preload beat valid
load_ready  out  1  preload beat accepted when valid&ready
load_addr  in  AW  preload address
load_data  in  DW  preload data
load_last  in  1  final preload beat
core_start  out  1  to core start/init input
core_halt  in  1  halt flag from core
cpu_mem_addr  in  AW  core memory address
cpu_mem_wdata  in  DW  core write data
cpu_mem_read  in  1  core read enable
cpu_mem_write  in  1  core write enable
mem_addr  out  AW  to data_mem DataAddress
mem_wdata  out  DW  to data_mem DataIn
mem_read  out  1  to data_mem ReadMem
mem_write  out  1  to data_mem WriteMem
mem_rdata  in  DW  data_mem DataOut, combinational read
rd_req_valid  in  1  readback request
rd_req_addr  in  AW  readback address
rd_rsp_valid  out  1  readback data valid
rd_rsp_data  out  DW  readback data
busy  out  1  high in LOAD, INIT and RUN
done  out  1  high in DONE
timeout  out  1  high in TIMEOUT
cycle_count  out  16  RUN cycles elapsed, excluding the halt cycle

Behaviour:

States and transitions:
- IDLE -> LOAD on go.
- LOAD -> INIT on an accepted beat with load_last=1.
- INIT -> RUN after INIT_CYCLES cycles.
- RUN -> DONE on core_halt=1.
- RUN -> TIMEOUT when cycle_count reaches MAX_CYCLES.
- DONE or TIMEOUT -> LOAD on go.

Reset values and reset rules:
- After reset: state=IDLE, core_start=1, load_ready=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rd_rsp_valid=0, rd_rsp_data=0, busy=0, done=0, timeout=0, cycle_count=0.
- While reset=1, mem_read and mem_write are forced to 0 combinationally, including a reset asserted mid-RUN or mid-LOAD. State returns to IDLE on the next edge.

Core start control:
- core_start=1 in every state except RUN, so the core is held in init outside a run.
- core_start=0 from the first RUN cycle.

Memory ownership (mux is combinational on the registered state):
- LOAD: load_ready=1. mem_write=load_valid, mem_addr=load_addr, mem_wdata=load_data in the same cycle (zero latency). The write and the load_last acceptance both happen on the same edge.
- RUN: mem_* = cpu_mem_*.
- DONE and TIMEOUT: mem_read=rd_req_valid, mem_addr=rd_req_addr, mem_write=0.
- IDLE and INIT: mem_read=0, mem_write=0.

Inputs ignored by state:
- cpu_mem_* are ignored outside RUN.
- load_* are ignored outside LOAD; load_ready=0 there.
- rd_req_* are ignored outside DONE and TIMEOUT.
- go is ignored while busy=1.

Readback:
- A request in cycle N gives rd_rsp_valid=1 in cycle N+1, with rd_rsp_data = mem_rdata registered at edge N.
- Back-to-back requests give one response per cycle.
- Otherwise rd_rsp_valid=0 and rd_rsp_data holds its last value.

Cycle counter:
- Cleared to 0 on the INIT -> RUN transition.
- In RUN, each cycle with core_halt=0 increments it by 1.
- If the incremented value equals MAX_CYCLES, the next state is TIMEOUT.
- core_halt=1 goes to DONE with no increment. Halt takes priority over timeout in the same cycle.
- Frozen in DONE and TIMEOUT; cleared on entry to LOAD.

Flags:
- done=1 in DONE only; timeout=1 in TIMEOUT only.
- Both drop on the go that starts the next LOAD.
- A LOAD with zero beats is illegal: at least one beat, the one carrying load_last, is required.

Test Plan:
1. Reset, then go; 3 beats (addr 0x10/0x11/0x12, data 0xA1/0xA2/0xA3, last on 3rd) -> mem_write high in 3 cycles with matching addr/data; core_start high through INIT (2 cycles) then low; busy=1 throughout.
2. RUN with the core model writing 0x5C to 0x20 at RUN cycle 4 and raising core_halt at RUN cycle 9 -> mem_write passes through at cycle 4; done=1 next cycle; cycle_count=9; core_start=1 again.
3. In DONE, rd_req_valid on 0x20, 0x10, 0x12 back-to-back -> rd_rsp_valid for 3 cycles, one cycle late, data 0x5C, 0xA1, 0xA3.
4. MAX_CYCLES=5, core never halts -> timeout=1 after 5 RUN cycles, cycle_count=5. Second case: halt in the cycle the count would reach 5 -> done=1, timeout=0, cycle_count=4.
5. reset asserted mid-RUN while cpu_mem_write=1 -> mem_write=0 that cycle; IDLE next; all outputs at reset values.
6. go pulsed during LOAD and RUN -> no effect. go in TIMEOUT -> LOAD, with timeout and cycle_count cleared.

Source files
------------

// File: rtl/prog_run_sequencer.sv
// prog_run_sequencer
// Run controller for the 9-bit-instruction single-cycle core. Owns the data
// memory port and hands it to one of three masters depending on the run
// phase: the preload stream (LOAD), the core (RUN) or the post-halt readback
// port (DONE / TIMEOUT). Holds the core in init everywhere except RUN.
//
// Ports:
//   CLK, reset            clock (posedge), synchronous active-high reset
//   go                    start pulse, honoured in IDLE, DONE and TIMEOUT
//   load_*                preload stream (valid/ready/addr/data/last)
//   core_start            core init input, low only in RUN
//   core_halt             core halt flag
//   cpu_mem_*             core side of the data memory port
//   mem_*                 data memory port (mem_rdata is a combinational read)
//   rd_req_*, rd_rsp_*    readback port, one-cycle response latency
//   busy, done, timeout   run status flags
//   cycle_count           RUN cycles elapsed, excluding the halt cycle
module prog_run_sequencer #(
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          core_start,
  input  logic          core_halt,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_mem_wdata,
  input  logic          cpu_mem_read,
  input  logic          cpu_mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          rd_req_valid,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_rsp_valid,
  output logic [DW-1:0] rd_rsp_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_INIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam logic [15:0] INIT_LAST_C = 16'(INIT_CYCLES - 1);

  state_t          state_r;
  state_t          state_s;
  logic [15:0]     init_cnt_r;
  logic [15:0]     cycle_count_r;
  logic [15:0]     cnt_inc_s;
  logic            rd_side_s;
  logic            rd_rsp_valid_r;
  logic [DW-1:0]   rd_rsp_data_r;
  logic [AW-1:0]   mem_addr_s;
  logic [DW-1:0]   mem_wdata_s;
  logic            mem_read_s;
  logic            mem_write_s;

  assign cnt_inc_s = cycle_count_r + 16'd1;
  assign rd_side_s = (state_r == ST_DONE) || (state_r == ST_TIMEOUT);

  // Next-state decode; halt is tested before the timeout compare so a halt
  // on the last budgeted cycle still ends in DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go) state_s = ST_LOAD;
        else    state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_valid && load_last) state_s = ST_INIT;
        else                         state_s = ST_LOAD;
      end
      ST_INIT: begin
        if (init_cnt_r == INIT_LAST_C) state_s = ST_RUN;
        else                           state_s = ST_INIT;
      end
      ST_RUN: begin
        if (core_halt)                     state_s = ST_DONE;
        else if (cnt_inc_s == MAX_CYCLES)  state_s = ST_TIMEOUT;
        else                               state_s = ST_RUN;
      end
      ST_DONE, ST_TIMEOUT: begin
        if (go) state_s = ST_LOAD;
        else    state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, init/cycle counters and the readback response register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      init_cnt_r     <= 16'd0;
      cycle_count_r  <= 16'd0;
      rd_rsp_valid_r <= 1'b0;
      rd_rsp_data_r  <= '0;
    end else begin
      state_r <= state_s;

      // Init counter only runs while in INIT, so it is zero on entry.
      if (state_r == ST_INIT) init_cnt_r <= init_cnt_r + 16'd1;
      else                    init_cnt_r <= 16'd0;

      if ((state_r == ST_INIT) && (state_s == ST_RUN))
        cycle_count_r <= 16'd0;
      else if ((state_s == ST_LOAD) && (state_r != ST_LOAD))
        cycle_count_r <= 16'd0;
      else if ((state_r == ST_RUN) && !core_halt)
        cycle_count_r <= cnt_inc_s;
      else
        cycle_count_r <= cycle_count_r;

      // Response data holds its last value when no request is serviced.
      if (rd_side_s && rd_req_valid) begin
        rd_rsp_valid_r <= 1'b1;
        rd_rsp_data_r  <= mem_rdata;
      end else begin
        rd_rsp_valid_r <= 1'b0;
        rd_rsp_data_r  <= rd_rsp_data_r;
      end
    end
  end

  // Memory port ownership, selected from the registered state.
  always_comb begin
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        mem_write_s = load_valid;
        mem_addr_s  = load_addr;
        mem_wdata_s = load_data;
      end
      ST_RUN: begin
        mem_write_s = cpu_mem_write;
        mem_read_s  = cpu_mem_read;
        mem_addr_s  = cpu_mem_addr;
        mem_wdata_s = cpu_mem_wdata;
      end
      ST_DONE, ST_TIMEOUT: begin
        mem_read_s = rd_req_valid;
        mem_addr_s = rd_req_addr;
      end
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Reset must kill strobes in the same cycle, even mid-RUN or mid-LOAD.
  assign mem_read     = reset ? 1'b0 : mem_read_s;
  assign mem_write    = reset ? 1'b0 : mem_write_s;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;

  assign load_ready   = (state_r == ST_LOAD);
  assign core_start   = (state_r != ST_RUN);
  assign busy         = (state_r == ST_LOAD) || (state_r == ST_INIT) || (state_r == ST_RUN);
  assign done         = (state_r == ST_DONE);
  assign timeout      = (state_r == ST_TIMEOUT);
  assign cycle_count  = cycle_count_r;
  assign rd_rsp_valid = rd_rsp_valid_r;
  assign rd_rsp_data  = rd_rsp_data_r;

endmodule
